// File: rtl/radix_frame_loader_if.sv
// Sample-in / frame-out handshake bundle for radix_frame_loader.
// in_last exists only when RADIX_FRAME_LOADER_LAST_EN is defined.
interface radix_frame_loader_if #(
  parameter int DATA_W = 32,
  parameter int RADIX  = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_re;
  logic [DATA_W-1:0]       in_img;
`ifdef RADIX_FRAME_LOADER_LAST_EN
  logic                    in_last;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic [RADIX*DATA_W-1:0] out_re;
  logic [RADIX*DATA_W-1:0] out_img;

  modport master (
    output in_valid, in_re, in_img, out_ready,
`ifdef RADIX_FRAME_LOADER_LAST_EN
    output in_last,
`endif
    input  in_ready, out_valid, out_re, out_img
  );

  modport slave (
    input  in_valid, in_re, in_img, out_ready,
`ifdef RADIX_FRAME_LOADER_LAST_EN
    input  in_last,
`endif
    output in_ready, out_valid, out_re, out_img
  );
endinterface

// File: rtl/radix_frame_loader.sv
// Ping-pong frame loader: gathers RADIX complex samples per bank and presents a
// whole frame to a radix butterfly. Macro RADIX_FRAME_LOADER_LAST_EN adds in_last.
module radix_frame_loader #(
  parameter int DATA_W = 32,
  parameter int RADIX  = 6
) (
  input logic                clk,
  input logic                rst,
  radix_frame_loader_if.slave bus
);
  localparam int              IDX_W    = (RADIX > 1) ? $clog2(RADIX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RADIX - 1);

  logic [DATA_W-1:0] bank_re  [2][RADIX];
  logic [DATA_W-1:0] bank_img [2][RADIX];
  logic [1:0]        full;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [IDX_W-1:0]  wr_idx;
  logic              accept;
  logic              take;
  logic              frame_end;
  logic              last_flag;

`ifdef RADIX_FRAME_LOADER_LAST_EN
  assign last_flag = bus.in_last;
`else
  assign last_flag = 1'b0;
`endif

  // Handshakes decode from the full flags only, so out_ready never reaches in_ready.
  assign bus.in_ready  = ~full[wr_ptr];
  assign bus.out_valid = full[rd_ptr];
  assign accept        = bus.in_valid & ~full[wr_ptr];
  assign take          = full[rd_ptr] & bus.out_ready;
  assign frame_end     = accept & ((wr_idx == LAST_IDX) | last_flag);

  // A bank being taken is full and a bank being closed is not, so the two
  // flag updates below always address different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 2'b00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      wr_idx <= '0;
    end else begin
      if (take) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
      if (frame_end) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
        wr_idx       <= '0;
      end else if (accept) begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
    end
  end

  // Lanes above an early in_last are zeroed so a short frame carries no stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < RADIX; k++) begin
          bank_re[b][k]  <= '0;
          bank_img[b][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < RADIX; k++) begin
        if (IDX_W'(k) == wr_idx) begin
          bank_re[wr_ptr][k]  <= bus.in_re;
          bank_img[wr_ptr][k] <= bus.in_img;
        end else if (last_flag && (IDX_W'(k) > wr_idx)) begin
          bank_re[wr_ptr][k]  <= '0;
          bank_img[wr_ptr][k] <= '0;
        end
      end
    end
  end

  always_comb begin
    bus.out_re  = '0;
    bus.out_img = '0;
    for (int k = 0; k < RADIX; k++) begin
      bus.out_re[k*DATA_W +: DATA_W]  = bank_re[rd_ptr][k];
      bus.out_img[k*DATA_W +: DATA_W] = bank_img[rd_ptr][k];
    end
  end
endmodule

// File: tb/tb_radix_frame_loader.sv
// Directed bench for radix_frame_loader: RADIX=6/DATA_W=32 plus a RADIX=4/DATA_W=16 instance.
module tb_radix_frame_loader;
  localparam int DW = 32;
  localparam int RX = 6;

  typedef struct {
    logic [31:0] re;
    logic [31:0] img;
    logic [31:0] exp_re;
    logic [31:0] exp_img;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  radix_frame_loader_if #(.DATA_W(DW), .RADIX(RX)) bus ();
  radix_frame_loader_if #(.DATA_W(16), .RADIX(4))  bus4 ();

  radix_frame_loader #(.DATA_W(DW), .RADIX(RX)) dut (.clk(clk), .rst(rst), .bus(bus));
  radix_frame_loader #(.DATA_W(16), .RADIX(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lre(input int k);
    return bus.out_re[k*DW +: DW];
  endfunction

  function automatic logic [31:0] lim(input int k);
    return bus.out_img[k*DW +: DW];
  endfunction

  function automatic logic [31:0] s(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  function automatic logic [31:0] si(input int i);
    return ~s(i);
  endfunction

  // One accepted sample; bounded wait for in_ready, then one edge.
  task automatic push(input logic [31:0] re, input logic [31:0] img, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_img   = img;
`ifdef RADIX_FRAME_LOADER_LAST_EN
    bus.in_last  = last;
`else
    if (last) $display("note: in_last ignored in this build");
`endif
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) check("push_timeout", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
`ifdef RADIX_FRAME_LOADER_LAST_EN
    bus.in_last  = 1'b0;
`endif
  endtask

  vec_t tv[6];
  int   low_cnt;
  int   pulses;

  initial begin
    tv[0] = '{32'h3f491a30, 32'h4246570a, 32'h3f491a30, 32'h4246570a};
    tv[1] = '{32'h3f800000, 32'h42480000, 32'h3f800000, 32'h42480000};
    tv[2] = '{32'h40000000, 32'h42500000, 32'h40000000, 32'h42500000};
    tv[3] = '{32'h40400000, 32'h42acd70a, 32'h40400000, 32'h42acd70a};
    tv[4] = '{32'h40800000, 32'h42c80000, 32'h40800000, 32'h42c80000};
    tv[5] = '{32'hbf15c290, 32'h4246570a, 32'hbf15c290, 32'h4246570a};

    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_img = '0; bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_re = '0; bus4.in_img = '0; bus4.out_ready = 1'b0;
`ifdef RADIX_FRAME_LOADER_LAST_EN
    bus.in_last = 1'b0;
    bus4.in_last = 1'b0;
`endif

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_re_zero", 64'(bus.out_re == '0), 64'd1);
    check("rst_out_img_zero", 64'(bus.out_img == '0), 64'd1);

    // Single frame from the table, out_ready high
    bus.out_ready = 1'b1;
    for (int i = 0; i < RX; i++) push(tv[i].re, tv[i].img, 1'b0);
    check("frame_out_valid", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < RX; k++) begin
      check($sformatf("frame_lane%0d_re", k), 64'(lre(k)), 64'(tv[k].exp_re));
      check($sformatf("frame_lane%0d_img", k), 64'(lim(k)), 64'(tv[k].exp_img));
    end
    tick();
    check("frame_taken", 64'(bus.out_valid), 64'd0);

    // Back-to-back four frames
    low_cnt = 0;
    pulses  = 0;
    for (int c = 0; c < 26; c++) begin
      if (c < 24) begin
        if (!bus.in_ready) low_cnt++;
        bus.in_valid = 1'b1;
        bus.in_re    = s(c);
        bus.in_img   = si(c);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (bus.out_valid) begin
        check($sformatf("b2b_f%0d_lane0", pulses), 64'(lre(0)), 64'(s(pulses*6)));
        check($sformatf("b2b_f%0d_lane5", pulses), 64'(lre(5)), 64'(s(pulses*6+5)));
        check($sformatf("b2b_f%0d_img3", pulses), 64'(lim(3)), 64'(si(pulses*6+3)));
        pulses++;
      end
    end
    check("b2b_ready_low_cycles", 64'(low_cnt), 64'd0);
    check("b2b_pulses", 64'(pulses), 64'd4);

    // Both banks full, stall, then ordered release
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(s(100+i), si(100+i), 1'b0);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    check("full_lane0", 64'(lre(0)), 64'(s(100)));
    check("full_lane5", 64'(lre(5)), 64'(s(105)));
    bus.in_valid = 1'b1;
    bus.in_re    = s(112);
    bus.in_img   = si(112);
    repeat (3) tick();
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    check("stall_hold_lane0", 64'(lre(0)), 64'(s(100)));
    check("stall_hold_img5", 64'(lim(5)), 64'(si(105)));
    bus.out_ready = 1'b1;
    tick();
    check("release_second_valid", 64'(bus.out_valid), 64'd1);
    check("release_second_lane0", 64'(lre(0)), 64'(s(106)));
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("release_drained", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    for (int i = 113; i < 118; i++) push(s(i), si(i), 1'b0);
    check("held_sample_lane0", 64'(lre(0)), 64'(s(112)));
    check("held_sample_lane5", 64'(lre(5)), 64'(s(117)));

    // Frame transfer and last-sample acceptance on the same edge
    for (int i = 118; i < 123; i++) push(s(i), si(i), 1'b0);
    bus.out_ready = 1'b1;
    push(s(123), si(123), 1'b0);
    check("same_edge_valid", 64'(bus.out_valid), 64'd1);
    check("same_edge_lane0", 64'(lre(0)), 64'(s(118)));
    check("same_edge_lane5", 64'(lre(5)), 64'(s(123)));
    check("same_edge_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("same_edge_drained", 64'(bus.out_valid), 64'd0);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) push(s(150+i), si(150+i), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_re_zero", 64'(bus.out_re == '0), 64'd1);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < RX; i++) push(s(200+i), si(200+i), 1'b0);
    check("midrst_clean_valid", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < RX; k++)
      check($sformatf("midrst_lane%0d", k), 64'(lre(k)), 64'(s(200+k)));
    tick();

`ifdef RADIX_FRAME_LOADER_LAST_EN
    // Short frame: lanes beyond in_last must be zero even over stale bank data
    for (int i = 0; i < RX; i++) push(s(300+i), si(300+i), 1'b0);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(s(400+i), si(400+i), 1'b0);
    push(32'hc1361234, 32'h12345678, 1'b1);
    check("last_valid", 64'(bus.out_valid), 64'd1);
    check("last_lane3_re", 64'(lre(3)), 64'h0000_0000_c136_1234);
    check("last_lane0_re", 64'(lre(0)), 64'(s(400)));
    check("last_lane4_re", 64'(lre(4)), 64'd0);
    check("last_lane5_re", 64'(lre(5)), 64'd0);
    check("last_lane4_img", 64'(lim(4)), 64'd0);
    check("last_lane5_img", 64'(lim(5)), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < RX; i++) push(s(500+i), si(500+i), 1'b0);
    check("after_last_lane0", 64'(lre(0)), 64'(s(500)));
    tick();
`endif

    // RADIX=4, DATA_W=16 instance with upper halves of the reference words
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_re    = tv[i].re[31:16];
      bus4.in_img   = tv[i].img[31:16];
      tick();
    end
    bus4.in_valid = 1'b0;
    check("r4_out_valid", 64'(bus4.out_valid), 64'd1);
    check("r4_out_re", bus4.out_re, 64'h4040_4000_3f80_3f49);
    check("r4_out_img", bus4.out_img, 64'h42ac_4250_4248_4246);
    tick();
    check("r4_taken", 64'(bus4.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
